// File: rtl/uart_rx_deshift.sv
// UART receive deserialiser: start, 8 data bits LSB first, parity, stop.
// Samples each bit at its midpoint using an oversampling tick and flags parity/framing errors.
module uart_rx_deshift #(
    parameter int unsigned OVERSAMPLE = 16,
    parameter bit          PARITY_ODD = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       Tick,
    input  logic       Rx,
    output logic [7:0] Dout,
    output logic       Valid,
    output logic       ParityErr,
    output logic       FrameErr,
    output logic       Busy
);

    localparam int unsigned TW = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] HalfLast = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] BitLast  = TW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop,
        StWaitHi
    } state_e;

    state_e          state_q, state_d;
    logic            rx_meta_q, rs_q;
    logic [TW-1:0]   tcnt_q, tcnt_d;
    logic [2:0]      bcnt_q, bcnt_d;
    logic [7:0]      shreg_q, shreg_d;
    logic            par_q, par_d;
    logic            perr_q, perr_d;
    logic [7:0]      dout_q, dout_d;
    logic            valid_q, valid_d;
    logic            parity_err_q, parity_err_d;
    logic            frame_err_q, frame_err_d;

    // Two-flop synchroniser; rs_q is the only view of the line the FSM uses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta_q <= 1'b1;
            rs_q      <= 1'b1;
        end else begin
            rx_meta_q <= Rx;
            rs_q      <= rx_meta_q;
        end
    end

    always_comb begin
        state_d      = state_q;
        tcnt_d       = tcnt_q;
        bcnt_d       = bcnt_q;
        shreg_d      = shreg_q;
        par_d        = par_q;
        perr_d       = perr_q;
        dout_d       = dout_q;
        valid_d      = 1'b0;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;

        case (state_q)
            StIdle: begin
                if (Tick && !rs_q) begin
                    state_d = StStart;
                    tcnt_d  = '0;
                end
            end
            StStart: begin
                if (Tick) begin
                    if (tcnt_q == HalfLast) begin
                        tcnt_d = '0;
                        if (rs_q) begin
                            // Line went back high before mid start bit: false start.
                            state_d = StIdle;
                        end else begin
                            state_d = StData;
                            bcnt_d  = '0;
                            par_d   = 1'b0;
                        end
                    end else begin
                        tcnt_d = tcnt_q + 1'b1;
                    end
                end
            end
            StData: begin
                if (Tick) begin
                    if (tcnt_q == BitLast) begin
                        tcnt_d  = '0;
                        shreg_d = {rs_q, shreg_q[7:1]};
                        par_d   = par_q ^ rs_q;
                        if (bcnt_q == 3'd7) begin
                            state_d = StParity;
                        end else begin
                            bcnt_d = bcnt_q + 3'd1;
                        end
                    end else begin
                        tcnt_d = tcnt_q + 1'b1;
                    end
                end
            end
            StParity: begin
                if (Tick) begin
                    if (tcnt_q == BitLast) begin
                        tcnt_d  = '0;
                        perr_d  = par_q ^ rs_q ^ PARITY_ODD;
                        state_d = StStop;
                    end else begin
                        tcnt_d = tcnt_q + 1'b1;
                    end
                end
            end
            StStop: begin
                if (Tick) begin
                    if (tcnt_q == BitLast) begin
                        tcnt_d       = '0;
                        dout_d       = shreg_q;
                        parity_err_d = perr_q;
                        frame_err_d  = ~rs_q;
                        valid_d      = 1'b1;
                        // Leaving at mid stop bit lets a back-to-back start edge be caught.
                        state_d      = rs_q ? StIdle : StWaitHi;
                    end else begin
                        tcnt_d = tcnt_q + 1'b1;
                    end
                end
            end
            StWaitHi: begin
                if (Tick && rs_q) begin
                    state_d = StIdle;
                    tcnt_d  = '0;
                end
            end
            default: begin
                state_d = StIdle;
                tcnt_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StIdle;
            tcnt_q       <= '0;
            bcnt_q       <= '0;
            shreg_q      <= '0;
            par_q        <= 1'b0;
            perr_q       <= 1'b0;
            dout_q       <= '0;
            valid_q      <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            tcnt_q       <= tcnt_d;
            bcnt_q       <= bcnt_d;
            shreg_q      <= shreg_d;
            par_q        <= par_d;
            perr_q       <= perr_d;
            dout_q       <= dout_d;
            valid_q      <= valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign Dout      = dout_q;
    assign Valid     = valid_q;
    assign ParityErr = parity_err_q;
    assign FrameErr  = frame_err_q;
    assign Busy      = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_deshift.sv
// Bench for uart_rx_deshift: even- and odd-parity instances share one line; a frame-level
// model (expected byte/flags queue) is checked every cycle, plus directed literal checks.
module tb_uart_rx_deshift;

    localparam int unsigned OS   = 16;
    localparam int unsigned TDIV = 3;

    logic       clk  = 1'b0;
    logic       rst  = 1'b1;
    logic       tick = 1'b0;
    logic       rx   = 1'b1;

    logic [7:0] dout_e, dout_o;
    logic       valid_e, valid_o;
    logic       perr_e, perr_o;
    logic       ferr_e, ferr_o;
    logic       busy_e, busy_o;

    always #5 clk = ~clk;

    uart_rx_deshift #(.OVERSAMPLE(OS), .PARITY_ODD(1'b0)) u_dut_even (
        .clk(clk), .rst(rst), .Tick(tick), .Rx(rx),
        .Dout(dout_e), .Valid(valid_e), .ParityErr(perr_e), .FrameErr(ferr_e), .Busy(busy_e)
    );

    uart_rx_deshift #(.OVERSAMPLE(OS), .PARITY_ODD(1'b1)) u_dut_odd (
        .clk(clk), .rst(rst), .Tick(tick), .Rx(rx),
        .Dout(dout_o), .Valid(valid_o), .ParityErr(perr_o), .FrameErr(ferr_o), .Busy(busy_o)
    );

    typedef struct packed {
        logic [7:0] data;
        logic       perr_even;
        logic       ferr;
    } exp_t;

    exp_t       exp_q[$];
    int         total = 0;
    int         bad = 0;
    int         valid_cnt = 0;
    logic [7:0] exp_dout = 8'h00;
    logic       exp_perr_e = 1'b0;
    logic       exp_perr_o = 1'b0;
    logic       exp_ferr = 1'b0;
    logic       prev_valid = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Per-cycle compare against the frame-level model.
    always @(posedge clk) begin : compare
        exp_t e;
        #1;
        if (!rst) begin
            exp_q.delete();
            exp_dout   = 8'h00;
            exp_perr_e = 1'b0;
            exp_perr_o = 1'b0;
            exp_ferr   = 1'b0;
            chk("rst_dout", {dout_o, dout_e}, 0);
            chk("rst_valid", {valid_o, valid_e}, 0);
            chk("rst_perr", {perr_o, perr_e}, 0);
            chk("rst_ferr", {ferr_o, ferr_e}, 0);
            chk("rst_busy", {busy_o, busy_e}, 0);
        end else begin
            if (valid_e) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL spurious_valid: got Valid=1 want no frame pending (t=%0t)",
                             $time);
                end else begin
                    e          = exp_q.pop_front();
                    exp_dout   = e.data;
                    exp_perr_e = e.perr_even;
                    exp_perr_o = !e.perr_even;
                    exp_ferr   = e.ferr;
                    valid_cnt++;
                end
            end
            chk("valid_one_clk", valid_e & prev_valid, 0);
            chk("valid_odd", valid_o, valid_e);
            chk("dout_even", dout_e, exp_dout);
            chk("dout_odd", dout_o, exp_dout);
            chk("perr_even", perr_e, exp_perr_e);
            chk("perr_odd", perr_o, exp_perr_o);
            chk("ferr_even", ferr_e, exp_ferr);
            chk("ferr_odd", ferr_o, exp_ferr);
        end
        prev_valid = valid_e;
    end

    task automatic step_tick();
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        repeat (TDIV - 1) @(negedge clk);
    endtask

    task automatic hold_bit(input logic b, input int unsigned n);
        rx = b;
        repeat (n) step_tick();
    endtask

    // Drives one frame; abort_at >= 0 pulls reset mid-way through that bit index.
    task automatic send_frame(input logic [7:0] d, input logic pbit, input logic stop,
                              input int abort_at);
        logic [10:0] bits;
        bits = {stop, pbit, d, 1'b0};
        for (int i = 0; i < 11; i++) begin
            rx = bits[i];
            if (i == 10) exp_q.push_back({d, (^d) ^ pbit, !stop});
            repeat (OS / 2) step_tick();
            if (i == abort_at) begin
                rst = 1'b0;
                repeat (4) @(negedge clk);
                rx  = 1'b1;
                rst = 1'b1;
                return;
            end
            if (i == 2) chk("busy_mid_frame", busy_e, 1);
            repeat (OS / 2) step_tick();
        end
        chk("valid_by_stop_end", exp_q.size(), 0);
        chk("busy_after_stop", busy_e, {31'b0, !stop});
    endtask

    initial begin
        int c0;
        logic [7:0] d;
        logic p, s;
        #2 rst = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        hold_bit(1'b1, 20);

        // 0xA5, even parity bit 0, good stop.
        c0 = valid_cnt;
        send_frame(8'hA5, 1'b0, 1'b1, -1);
        chk("a5_count", valid_cnt - c0, 1);
        chk("a5_model", exp_dout, 8'hA5);
        chk("a5_dout", dout_e, 8'hA5);
        chk("a5_flags", {perr_e, ferr_e}, 0);
        hold_bit(1'b1, 5);

        // 0x01 with parity 0: error for even, fine for odd.
        send_frame(8'h01, 1'b0, 1'b1, -1);
        chk("p01_dout", dout_e, 8'h01);
        chk("p01_perr_even", perr_e, 1);
        chk("p01_perr_odd", perr_o, 0);
        chk("p01_ferr", ferr_e, 0);

        // 0x3C with bad stop, line held low, then 0x55.
        c0 = valid_cnt;
        send_frame(8'h3C, 1'b0, 1'b0, -1);
        chk("3c_dout", dout_e, 8'h3C);
        chk("3c_ferr", ferr_e, 1);
        hold_bit(1'b0, 3 * OS);
        chk("3c_busy_low", busy_e, 1);
        hold_bit(1'b1, OS);
        send_frame(8'h55, 1'b0, 1'b1, -1);
        chk("55_count", valid_cnt - c0, 2);
        chk("55_dout", dout_e, 8'h55);
        chk("55_ferr", ferr_e, 0);

        // Short low glitch is a false start.
        c0 = valid_cnt;
        hold_bit(1'b0, OS / 4);
        hold_bit(1'b1, 2 * OS);
        chk("glitch_count", valid_cnt - c0, 0);
        chk("glitch_busy", busy_e, 0);
        chk("glitch_dout", dout_e, 8'h55);

        // Reset during data bit 4 of 0x96, then 0xFF.
        c0 = valid_cnt;
        send_frame(8'h96, 1'b0, 1'b1, 5);
        hold_bit(1'b1, OS);
        chk("abort_count", valid_cnt - c0, 0);
        chk("abort_dout", dout_e, 8'h00);
        send_frame(8'hFF, 1'b0, 1'b1, -1);
        chk("ff_dout", dout_e, 8'hFF);
        hold_bit(1'b1, 3);

        // Back-to-back 0x00 then 0xFF with no idle gap.
        c0 = valid_cnt;
        send_frame(8'h00, 1'b0, 1'b1, -1);
        chk("b2b_first", dout_e, 8'h00);
        send_frame(8'hFF, 1'b0, 1'b1, -1);
        chk("b2b_count", valid_cnt - c0, 2);
        chk("b2b_second", dout_e, 8'hFF);
        chk("b2b_flags", {perr_e, ferr_e}, 0);

        // Randomised frames: occasional bad parity and bad stop, random gaps.
        for (int n = 0; n < 40; n++) begin
            d = 8'($urandom);
            p = ($urandom_range(0, 3) == 0) ? !(^d) : (^d);
            s = ($urandom_range(0, 5) != 0);
            send_frame(d, p, s, -1);
            if (!s) begin
                hold_bit(1'b0, $urandom_range(0, 2 * OS));
                hold_bit(1'b1, $urandom_range(OS / 4, OS));
            end else begin
                hold_bit(1'b1, $urandom_range(0, 20));
            end
        end

        hold_bit(1'b1, OS);
        chk("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
